serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor; the inverse operation of the team's 4-bit ripple adder datapath.
- Computes diff = a - b - bin one bit per clock, LSB first, through a single full-adder cell. The cell is fed a, ~b and an inverted borrow.
- Used where area matters more than latency. It sits behind a valid/ready operand interface and drives a valid/ready result interface.

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 181 ++++++++++++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand and result valid/ready channels of the bit-serial subtractor.
// The master is the producer/consumer side and the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start_valid, a, b, bin, res_ready,
    input  start_ready, res_valid, diff, borrow, ovf
  );

  modport slave (
    input  start_valid, a, b, bin, res_ready,
    output start_ready, res_valid, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// computed as a + ~b + ~bin through one full-adder cell.
module serial_subtractor_chk #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             start_ready,
  input logic             busy,
  input logic             res_valid,
  input logic             res_ready,
  input logic [WIDTH-1:0] diff,
  input logic             borrow,
  input logic             ovf
);
  // A pending result must stay valid and frozen until the consumer accepts it.
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(diff) && $stable(borrow) && $stable(ovf)));

  // Ready to accept exactly when idle.
  a_ready: assert property (@(posedge clk) disable iff (!rst_n)
    start_ready == !busy);

  // A valid result only exists outside IDLE.
  a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
    res_valid |-> busy);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave io,
  output logic               busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (ci & (x ^ y));
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] nb_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic             sum_s;
  logic             cout_s;
  logic             last_bit_s;
  logic             accept_s;
  logic             res_hs_s;
  logic [WIDTH-1:0] res_full_s;

  assign sum_s      = fa_sum(a_sr_r[0], nb_sr_r[0], c_r);
  assign cout_s     = fa_carry(a_sr_r[0], nb_sr_r[0], c_r);
  assign last_bit_s = (cnt_r == CNT_LAST);
  assign accept_s   = io.start_valid && (state_r == ST_IDLE);
  assign res_hs_s   = io.res_ready && (state_r == ST_DONE);
  assign res_full_s = {sum_s, res_sr_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_bit_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (res_hs_s) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Status decoded from state.
  always_comb begin
    io.start_ready = 1'b0;
    busy           = 1'b1;
    case (state_r)
      ST_IDLE: begin
        io.start_ready = 1'b1;
        busy           = 1'b0;
      end
      ST_RUN, ST_DONE: begin
        io.start_ready = 1'b0;
        busy           = 1'b1;
      end
      default: begin
        io.start_ready = 1'b0;
        busy           = 1'b1;
      end
    endcase
  end

  // Serial datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r       <= {WIDTH{1'b0}};
      nb_sr_r      <= {WIDTH{1'b0}};
      res_sr_r     <= {WIDTH{1'b0}};
      c_r          <= 1'b0;
      cnt_r        <= CNT_ZERO;
      io.diff      <= {WIDTH{1'b0}};
      io.borrow    <= 1'b0;
      io.ovf       <= 1'b0;
      io.res_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sr_r  <= io.a;
            nb_sr_r <= ~io.b;
            c_r     <= ~io.bin;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_RUN: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          nb_sr_r  <= {1'b0, nb_sr_r[WIDTH-1:1]};
          res_sr_r <= res_full_s;
          c_r      <= cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_bit_s) begin
            // c_r here is the carry into the MSB; the adder's carry-out is the inverted borrow.
            io.diff      <= res_full_s;
            io.borrow    <= ~cout_s;
            io.ovf       <= c_r ^ cout_s;
            io.res_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (io.res_ready) io.res_valid <= 1'b0;
        end
        default: io.res_valid <= 1'b0;
      endcase
    end
  end

  serial_subtractor_chk #(.WIDTH(WIDTH)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_ready (io.start_ready),
    .busy        (busy),
    .res_valid   (io.res_valid),
    .res_ready   (io.res_ready),
    .diff        (io.diff),
    .borrow      (io.borrow),
    .ovf         (io.ovf)
  );
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an integer model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic busy;
  int   errors;
  int   checks;

  serial_subtractor_if #(.WIDTH(W)) io ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: subtraction on plain integers, signed view by reinterpreting the MSB.
  function automatic void model(input int ta, input int tb, input int tbin,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int sa, sb, s;
    d  = W'(ta - tb - tbin);
    bo = (ta < tb + tbin);
    sa = (ta >= 2**(W-1)) ? ta - 2**W : ta;
    sb = (tb >= 2**(W-1)) ? tb - 2**W : tb;
    s  = sa - sb - tbin;
    ov = (s < -(2**(W-1))) || (s > 2**(W-1) - 1);
  endfunction

  task automatic run_op(input int ta, input int tb, input int tbin, input int stall, input bit inject);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           lat;
    model(ta, tb, tbin, ed, eb, eo);
    @(negedge clk);
    check_eq("start_ready_idle", io.start_ready, 1);
    io.start_valid = 1'b1;
    io.a   = W'(ta);
    io.b   = W'(tb);
    io.bin = tbin[0];
    io.res_ready = 1'b0;
    @(posedge clk); #1;
    io.start_valid = 1'b0;
    io.a   = W'($urandom);
    io.b   = W'($urandom);
    io.bin = 1'($urandom);
    check_eq("busy_run", busy, 1);
    check_eq("start_ready_run", io.start_ready, 0);
    lat = 0;
    while (!io.res_valid && lat < 20) begin
      if (inject && lat == 1) begin
        io.start_valid = 1'b1;
        io.a = W'(1);
        io.b = W'(1);
      end else begin
        io.start_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    io.start_valid = 1'b0;
    check_eq("latency", lat, W);
    check_eq("diff", io.diff, ed);
    check_eq("borrow", io.borrow, eb);
    check_eq("ovf", io.ovf, eo);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", io.res_valid, 1);
      check_eq("stall_diff", io.diff, ed);
    end
    io.res_ready = 1'b1;
    @(posedge clk); #1;
    io.res_ready = 1'b0;
    check_eq("valid_drop", io.res_valid, 0);
    check_eq("idle_after_hs", busy, 0);
    check_eq("ready_after_hs", io.start_ready, 1);
    check_eq("diff_held", io.diff, ed);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    errors = 0;
    checks = 0;
    io.start_valid = 1'b0;
    io.res_ready = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_start_ready", io.start_ready, 1);
    check_eq("rst_res_valid", io.res_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_diff", io.diff, 0);
    check_eq("rst_borrow", io.borrow, 0);
    check_eq("rst_ovf", io.ovf, 0);

    run_op(9, 3, 0, 0, 1'b0);
    run_op(3, 5, 0, 0, 1'b0);
    run_op(0, 0, 1, 0, 1'b0);
    run_op(8, 1, 0, 3, 1'b0);
    run_op(7, 15, 0, 0, 1'b1);

    // Abort an operation two edges into RUN.
    @(negedge clk);
    io.start_valid = 1'b1;
    io.a = W'(12);
    io.b = W'(4);
    io.bin = 1'b0;
    @(posedge clk); #1;
    io.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_res_valid", io.res_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_start_ready", io.start_ready, 1);
    check_eq("abort_diff", io.diff, 0);
    check_eq("abort_borrow", io.borrow, 0);
    check_eq("abort_ovf", io.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_pulse", io.res_valid, 0);
    end
    run_op(5, 2, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
